// File: rtl/ucie_ctl_rx_pkg.sv
// rtl/ucie_ctl_rx_pkg.sv - shared FSM encodings and sizing for the RX buffer controller
package ucie_ctl_rx_pkg;

    localparam int RX_DEPTH = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    // Counter must hold DEPTH itself, so it needs 2**CW > DEPTH.
    function automatic int cw_for(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ucie_ctl_rx_occ_counter.sv
// rtl/ucie_ctl_rx_occ_counter.sv - saturating up/down occupancy counter driven by push/pop strobes
module ucie_ctl_rx_occ_counter
    import ucie_ctl_rx_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH,
    parameter int CW    = cw_for(RX_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    output logic [CW-1:0] o_occupancy,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_illegal
);

    logic [CW-1:0] occ;
    logic          push_only;
    logic          pop_only;

    assign push_only = i_push && !i_pop;
    assign pop_only  = i_pop && !i_push;
    assign o_full    = (occ == CW'(DEPTH));
    assign o_empty   = (occ == '0);
    // A simultaneous push and pop is always legal, even at the extremes.
    assign o_illegal = (push_only && o_full) || (pop_only && o_empty);
    assign o_occupancy = occ;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            occ <= '0;
        end else if (push_only && !o_full) begin
            occ <= occ + 1'b1;
        end else if (pop_only && !o_empty) begin
            occ <= occ - 1'b1;
        end
    end

endmodule

// File: rtl/ucie_ctl_rx_buffer_ctrl.sv
// rtl/ucie_ctl_rx_buffer_ctrl.sv - RX buffer sequencer: enable, occupancy, credits, drain; UCIE_CTL_RX_DRAIN_TIMEOUT_EN adds a drain timeout
module ucie_ctl_rx_buffer_ctrl
    import ucie_ctl_rx_pkg::*;
#(
    parameter int DEPTH    = RX_DEPTH,
    parameter int CW       = cw_for(RX_DEPTH),
    parameter int DRAIN_TO = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_link_active,
    input  logic          i_flush_req,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_overflow,
    output logic          o_buffer_en,
    output logic          o_credit_return,
    output logic [CW-1:0] o_credits,
    output logic [1:0]    o_state,
    output logic          o_drain_done,
    output logic          o_error
);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] occ;
    logic          occ_full;
    logic          occ_empty;
    logic          occ_illegal;
    logic          timeout;
    logic          buffer_en_d;
    logic          credit_d;
    logic          drain_done_d;
    logic          error_d;
    logic          unused_cfg;

    ucie_ctl_rx_occ_counter #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_occ (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (i_push),
        .i_pop       (i_pop),
        .o_occupancy (occ),
        .o_full      (occ_full),
        .o_empty     (occ_empty),
        .o_illegal   (occ_illegal)
    );

`ifdef UCIE_CTL_RX_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(DRAIN_TO + 1);
    logic [TW-1:0] drain_cnt;

    // Count is 0 in the first DRAIN cycle, so ERROR lands DRAIN_TO cycles after entry.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            drain_cnt <= '0;
        end else if (state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else if (drain_cnt != TW'(DRAIN_TO)) begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end

    assign timeout = (state == ST_DRAIN) && !occ_empty && (drain_cnt >= TW'(DRAIN_TO - 1));
    assign unused_cfg = occ_full;
`else
    assign timeout = 1'b0;
    assign unused_cfg = ^{occ_full, 32'(DRAIN_TO)};
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (i_link_active && !i_flush_req) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (!i_link_active || i_flush_req) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (occ_empty && !i_push) state_nxt = ST_IDLE;
            default:   state_nxt = ST_ERROR;
        endcase
        if (i_overflow || occ_illegal || timeout) begin
            state_nxt = ST_ERROR;
        end
    end

    always_comb begin
        buffer_en_d  = (state_nxt == ST_ACTIVE) || (state_nxt == ST_DRAIN);
        credit_d     = (state == ST_ACTIVE) && i_pop;
        drain_done_d = (state == ST_DRAIN) && (state_nxt == ST_IDLE);
        error_d      = o_error || (state_nxt == ST_ERROR);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_buffer_en     <= 1'b0;
            o_credit_return <= 1'b0;
            o_drain_done    <= 1'b0;
            o_error         <= 1'b0;
        end else begin
            o_buffer_en     <= buffer_en_d;
            o_credit_return <= credit_d;
            o_drain_done    <= drain_done_d;
            o_error         <= error_d;
        end
    end

    assign o_state   = state;
    assign o_credits = CW'(DEPTH) - occ;

endmodule
